// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write buffer.
// Entry fields are sized from the default register-file geometry below.
package regfile_pkg;

   localparam int DEF_WORD_WIDTH = 32;
   localparam int DEF_LENGTH     = 128;
   localparam int DEF_DEPTH      = 4;

   function automatic int addr_width(input int len);
      return (len > 1) ? $clog2(len) : 1;
   endfunction

   localparam int DEF_ADDR_WIDTH = addr_width(DEF_LENGTH);

   typedef struct packed {
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_WORD_WIDTH-1:0] data;
      logic                      valid;
   } entry_t;

endpackage

// File: rtl/wbuf_match.sv
// Youngest-match search over the circular entry array, scanning oldest to
// youngest from base so the last hit seen is the youngest one.
module wbuf_match #(
   parameter int DEPTH = 4,
   parameter int AW    = 7
) (
   input  logic [AW-1:0]            addrs [DEPTH],
   input  logic [DEPTH-1:0]         valids,
   input  logic [$clog2(DEPTH)-1:0] base,
   input  logic                     skip_base,
   input  logic [AW-1:0]            key,
   output logic                     hit,
   output logic [$clog2(DEPTH)-1:0] idx
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] pos;

   always_comb begin
      hit = 1'b0;
      idx = base;
      pos = base;
      for (int k = 0; k < DEPTH; k++) begin
         pos = base + PW'(k);
         if (valids[pos] && (addrs[pos] == key) && !(skip_base && (k == 0))) begin
            hit = 1'b1;
            idx = pos;
         end
      end
   end

endmodule

// File: rtl/regfile_write_buffer.sv
// In-order write queue in front of the register-file write port with a
// read-after-write lookup. Optional macro WRITE_COALESCE_EN merges same-address writes.
module regfile_write_buffer
   import regfile_pkg::*;
#(
   parameter int word_width = DEF_WORD_WIDTH,
   parameter int length     = DEF_LENGTH,
   parameter int DEPTH      = DEF_DEPTH
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [addr_width(length)-1:0] in_addr,
   input  logic [word_width-1:0]         in_data,
   input  logic                          drain_en,
   output logic                          wr_write,
   output logic [addr_width(length)-1:0] wr_addr,
   output logic [word_width-1:0]         wr_data,
   input  logic [addr_width(length)-1:0] lk_addr,
   output logic                          lk_hit,
   output logic [word_width-1:0]         lk_data,
   output logic [$clog2(DEPTH):0]        count,
   output logic                          empty
);

   localparam int AW = addr_width(length);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   entry_t        mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count_q;

   logic [AW-1:0]    addrs [DEPTH];
   logic [DEPTH-1:0] valids;
   logic             push, pop, alloc;
   logic             lk_match;
   logic [PW-1:0]    lk_idx;
   logic             co_hit;
   logic [PW-1:0]    co_idx;

   always_comb begin
      valids = '0;
      for (int i = 0; i < DEPTH; i++) begin
         addrs[i]  = mem[i].addr;
         valids[i] = mem[i].valid;
      end
   end

   // Full/empty come from the counter only; a pop in the same cycle does not free a slot.
   assign count    = count_q;
   assign empty    = (count_q == '0);
   assign in_ready = (count_q < CW'(DEPTH));
   assign push     = in_valid & in_ready;
   assign pop      = !empty & drain_en;
   assign wr_write = pop;
   assign wr_addr  = empty ? '0 : mem[rd_ptr].addr;
   assign wr_data  = empty ? '0 : mem[rd_ptr].data;

   // The head stays searchable while popping: the register file has not updated yet.
   wbuf_match #(.DEPTH(DEPTH), .AW(AW)) u_lookup (
      .addrs     (addrs),
      .valids    (valids),
      .base      (rd_ptr),
      .skip_base (1'b0),
      .key       (lk_addr),
      .hit       (lk_match),
      .idx       (lk_idx)
   );

   assign lk_hit  = lk_match;
   assign lk_data = lk_match ? mem[lk_idx].data : '0;

   wbuf_match #(.DEPTH(DEPTH), .AW(AW)) u_coalesce (
      .addrs     (addrs),
      .valids    (valids),
      .base      (rd_ptr),
      .skip_base (pop),
      .key       (in_addr),
      .hit       (co_hit),
      .idx       (co_idx)
   );

`ifdef WRITE_COALESCE_EN
   assign alloc = push & !co_hit;
`else
   assign alloc = push;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (pop) begin
            mem[rd_ptr].valid <= 1'b0;
            rd_ptr            <= rd_ptr + 1'b1;
         end
`ifdef WRITE_COALESCE_EN
         if (push && co_hit) mem[co_idx].data <= in_data;
`endif
         if (alloc) begin
            mem[wr_ptr] <= '{addr: in_addr, data: in_data, valid: 1'b1};
            wr_ptr      <= wr_ptr + 1'b1;
         end
         count_q <= count_q + CW'(alloc) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Randomized and directed bench for regfile_write_buffer against a
// queue-based model of pending writes.
module tb_regfile_write_buffer;
   import regfile_pkg::*;

   localparam int W  = 32;
   localparam int AW = 7;
   localparam int D  = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] in_addr = '0;
   logic [W-1:0]  in_data = '0;
   logic          drain_en = 1'b0;
   logic          wr_write;
   logic [AW-1:0] wr_addr;
   logic [W-1:0]  wr_data;
   logic [AW-1:0] lk_addr = '0;
   logic          lk_hit;
   logic [W-1:0]  lk_data;
   logic [2:0]    count;
   logic          empty;

   int checks = 0;
   int errors = 0;
   int n_writes = 0;

   // Pending writes oldest-first, each entry {addr, data}.
   logic [AW+W-1:0] exp_q[$];

   regfile_write_buffer #(.word_width(W), .length(128), .DEPTH(D)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .drain_en(drain_en),
      .wr_write(wr_write), .wr_addr(wr_addr), .wr_data(wr_data),
      .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
      .count(count), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, compare outputs with the model, then advance the model.
   task automatic step(input logic rst, input logic iv, input logic [AW-1:0] ia,
                       input logic [W-1:0] id, input logic de, input logic [AW-1:0] la,
                       input bit chk);
      int  n;
      bit  ready, popping, found;
      logic [W-1:0] lk_exp;
      @(negedge clk);
      reset = rst; in_valid = iv; in_addr = ia; in_data = id; drain_en = de; lk_addr = la;
      #1;
      n       = exp_q.size();
      ready   = (n < D);
      popping = (n > 0) && de;
      found   = 1'b0;
      lk_exp  = '0;
      for (int i = n - 1; i >= 0; i--) begin
         if (!found && exp_q[i][AW+W-1:W] == la) begin
            found  = 1'b1;
            lk_exp = exp_q[i][W-1:0];
         end
      end
      if (chk) begin
         check_eq("in_ready", 64'(in_ready), 64'(ready));
         check_eq("empty",    64'(empty),    64'(n == 0));
         check_eq("count",    64'(count),    64'(n));
         check_eq("wr_write", 64'(wr_write), 64'(popping));
         check_eq("wr_addr",  64'(wr_addr),  (n > 0) ? 64'(exp_q[0][AW+W-1:W]) : 64'd0);
         check_eq("wr_data",  64'(wr_data),  (n > 0) ? 64'(exp_q[0][W-1:0]) : 64'd0);
         check_eq("lk_hit",   64'(lk_hit),   64'(found));
         check_eq("lk_data",  64'(lk_data),  64'(lk_exp));
      end
      if (popping) n_writes++;
      if (rst) begin
         exp_q.delete();
      end else begin
         if (iv && ready) begin
`ifdef WRITE_COALESCE_EN
            bit merged = 1'b0;
            for (int i = n - 1; i >= (popping ? 1 : 0); i--) begin
               if (!merged && exp_q[i][AW+W-1:W] == ia) begin
                  merged   = 1'b1;
                  exp_q[i] = {ia, id};
               end
            end
            if (!merged) exp_q.push_back({ia, id});
`else
            exp_q.push_back({ia, id});
`endif
         end
         if (popping) void'(exp_q.pop_front());
      end
   endtask

   initial begin
      step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);

      // Single write held, then drained.
      step(1'b0, 1'b1, 7'd5, 32'hA5A5A5A5, 1'b0, 7'd5, 1'b1);
      step(1'b0, 1'b0, '0, '0, 1'b0, 7'd5, 1'b1);
      step(1'b0, 1'b0, '0, '0, 1'b1, 7'd5, 1'b1);
      step(1'b0, 1'b0, '0, '0, 1'b1, 7'd5, 1'b1);

      // Fill to DEPTH, attempt a fifth, then drain in order.
      for (int i = 1; i <= 5; i++)
         step(1'b0, 1'b1, 7'(i), 32'(i * 'h11), 1'b0, 7'd3, 1'b1);
      for (int i = 0; i < 5; i++)
         step(1'b0, 1'b0, '0, '0, 1'b1, 7'd3, 1'b1);

      // Same-address forwarding picks the youngest value.
      step(1'b0, 1'b1, 7'd7, 32'h1, 1'b0, 7'd7, 1'b1);
      step(1'b0, 1'b1, 7'd7, 32'h2, 1'b0, 7'd7, 1'b1);
      step(1'b0, 1'b0, '0, '0, 1'b0, 7'd7, 1'b1);
      step(1'b0, 1'b0, '0, '0, 1'b0, 7'd8, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 7'd7, 1'b1);

      // Full buffer with drain and input held.
      for (int i = 0; i < 12; i++)
         step(1'b0, 1'b1, 7'(16 + i), 32'(32'h100 + i), (i >= 4), 7'(16 + i), 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 7'd20, 1'b1);

      // Reset with three pending writes.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 7'(40 + i), 32'(i + 1), 1'b0, 7'd40, 1'b1);
      step(1'b1, 1'b0, '0, '0, 1'b1, 7'd40, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 7'd40, 1'b1);

      // Same-address pair: merged or kept separate depending on build.
      step(1'b0, 1'b1, 7'd3, 32'h10, 1'b0, 7'd3, 1'b1);
      step(1'b0, 1'b1, 7'd3, 32'h20, 1'b0, 7'd3, 1'b1);
      step(1'b0, 1'b0, '0, '0, 1'b0, 7'd3, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 7'd3, 1'b1);

      // Random traffic on a narrow address range to provoke matches.
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
              7'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 1) == 1),
              7'($urandom_range(0, 7)), 1'b1);
      end
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, '0, 1'b1, '0, 1'b1);

      check_eq("writes_seen", 64'(n_writes > 0), 64'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
- Small write-request queue that sits directly upstream of the register file's write port.
- Accepts (address, data) write requests over a valid/ready handshake, buffers up to DEPTH of them in order, and drains one per cycle into the register file's write / write address / write data inputs.
- Provides a combinational lookup port so a consumer can read the newest not-yet-committed value of an address (read-after-write forwarding around the buffer).

Parameters:
- word_width, 32, data width; must match the register file.
- length, 128, number of register file words; address width is $clog2(length).
- DEPTH, 4, buffer entries; power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  write request present.
- in_ready  output  1  buffer can accept; equals (count < DEPTH).
- in_addr  input  $clog2(length)  request address.
- in_data  input  word_width  request data.
- drain_en  input  1  register file write port available this cycle.
- wr_write  output  1  write strobe to the register file.
- wr_addr  output  $clog2(length)  write address to the register file.
- wr_data  output  word_width  write data to the register file.
- lk_addr  input  $clog2(length)  lookup address.
- lk_hit  output  1  a pending entry matches lk_addr.
- lk_data  output  word_width  data of the newest matching entry; 0 when no hit.
- count  output  $clog2(DEPTH)+1  occupied entries.
- empty  output  1  count == 0.

Behaviour:
- Storage: circular buffer with rd_ptr, wr_ptr and count; each entry holds addr, data and valid. Pointers wrap modulo DEPTH.
- Push: in_valid & in_ready at a clock edge writes the entry at wr_ptr and advances wr_ptr.
- in_ready depends only on count; it does not account for a same-cycle pop. A full buffer therefore rejects input even while draining.
- Pop: wr_write = !empty & drain_en, combinational.
  - wr_addr and wr_data always present the head entry; both are 0 when empty.
  - The pop takes effect at the same edge the register file captures the write.
- Latency: a request accepted at edge N is at the head no earlier than after edge N, so the earliest wr_write is in cycle N+1.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Ordering is strict FIFO. Two writes to the same address both reach the register file, in order.
- Lookup: combinational search over valid entries.
  - When several entries match, the youngest (closest to wr_ptr) wins.
  - The head entry popping this cycle is still searched, since the register file has not yet updated.
  - The entry being pushed this cycle is not visible until the next cycle.
  - lk_hit = 0 and lk_data = 0 when empty or when nothing matches.
- drain_en low: no pop; the buffer holds its contents and can fill to DEPTH.
- Reset: count = 0, pointers = 0, all valid bits cleared.
  - Outputs after reset: in_ready = 1, wr_write = 0, wr_addr = 0, wr_data = 0, lk_hit = 0, lk_data = 0, empty = 1.
  - Reset mid-operation discards pending writes; none are emitted afterwards.
- No state machine beyond the occupancy counter; full and empty are derived from count, never from pointer equality.

Optional Feature:
- Macro: WRITE_COALESCE_EN.
- Defined: an accepted request whose in_addr matches a valid entry other than the head being popped this cycle overwrites that entry's data in place. No new entry is allocated and count is unchanged.
  - If several entries match, the youngest is updated.
  - in_ready is still (count < DEPTH).
- Undefined: every accepted request allocates a new entry, as described in Behaviour.

Decomposition:
- Shared package regfile_pkg holds:
  - the address-width function of length;
  - the entry struct typedef (addr, data, valid);
  - a constant for the default DEPTH.
- One sub-module, wbuf_match: a combinational youngest-match priority search over the entry array, rotated from rd_ptr. It produces hit and index and is reused by both the lookup path and the coalesce path.

Test Plan:
- Reset, then push (addr 5, data 0xA5A5A5A5) with drain_en = 0 -> count = 1 and no wr_write. Raise drain_en -> wr_write = 1, wr_addr = 5, wr_data = 0xA5A5A5A5 for one cycle, then empty = 1.
- drain_en = 0; push addr 1..4 with data 0x11..0x44 -> in_ready = 0 at count = 4 and a fifth request is not accepted. Enable drain -> writes emitted in order 1, 2, 3, 4 on four consecutive cycles.
- Push addr 7 with 0x1, then addr 7 with 0x2, drain held off -> lk_addr = 7 gives lk_hit = 1, lk_data = 0x2. lk_addr = 8 gives lk_hit = 0, lk_data = 0.
- Full buffer with drain_en = 1 and in_valid held -> one pop per cycle; a new push is accepted only once count < 4, with no loss and no reordering.
- Reset asserted with 3 entries pending -> the next cycle shows count = 0 and wr_write = 0, and no stale write ever appears.
- With WRITE_COALESCE_EN: push addr 3 with 0x10, then addr 3 with 0x20 -> count = 1 and exactly one write of 0x20 emitted. Without the macro -> count = 2 and writes of 0x10 then 0x20.
